chrono_ctrl: RTL and testbench
==============================

CHRONO_CTRL -- requirements
Module: chrono_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: number of consecutive cycles a synchronized button level must hold before it is accepted.
REQ-002 SHALL have parameter TICK_DIV, default 500000: prescaler modulus; one tick per TICK_DIV ClkIn cycles (100 ms at 5 MHz).
REQ-003 SHALL have parameter PRE_W, default 19: prescaler width; TICK_DIV <= 2^PRE_W.
REQ-004 SHALL have parameter DB_W, default 16: debounce counter width; DEBOUNCE_CYCLES <= 2^DB_W.
REQ-005 ClkIn  input  1  system clock; all state updates on the rising edge.
REQ-006 nRstIn  input  1  asynchronous, active-low reset.
REQ-007 BtnStartStop  input  1  raw start/stop button, active-high, asynchronous to ClkIn, may bounce.
REQ-008 BtnLapClear  input  1  raw lap/clear button, active-high, asynchronous to ClkIn, may bounce.
REQ-009 TickEn  output  1  one-cycle count-enable pulse for the downstream counter.
REQ-010 CntClr  output  1  one-cycle synchronous clear pulse for the downstream counter.
REQ-011 LapHold  output  1  level; high means display latches must freeze.
REQ-012 State  output  2  current FSM state code.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer holding a "stable" level.
REQ-014 Debouncer: counter clears whenever the synchronized level equals stable; otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, stable takes the synchronized level and the counter clears.
REQ-015 A press event SHALL be a one-cycle internal pulse on a stable 0->1 transition. Release (1->0) generates no event.
REQ-016 Press-event latency SHALL be exactly DEBOUNCE_CYCLES+2 ClkIn edges from the first edge sampling the steady high raw level.
REQ-017 The FSM SHALL use states IDLE=00, RUN=01, PAUSE=10, LAP=11. State SHALL be the registered state.
REQ-018 Transitions: IDLE: SS->RUN; LC ignored.
REQ-019 Transitions: RUN: SS->PAUSE; LC->LAP.
REQ-020 Transitions: LAP: LC->RUN; SS->PAUSE.
REQ-021 Transitions: PAUSE: SS->RUN; LC->IDLE.
REQ-022 If SS and LC press events occur in the same cycle, SS SHALL be taken and LC discarded.
REQ-023 Prescaler behaviour by registered state: in RUN or LAP it counts 0..TICK_DIV-1 and wraps to 0; in PAUSE it holds; in IDLE it is forced to 0.
REQ-024 TickEn SHALL be registered and high for exactly one cycle, in the cycle after the prescaler equals TICK_DIV-1 while the registered state is RUN or LAP. This holds even if a transition to PAUSE occurs on that same edge.
REQ-025 Counting SHALL continue during LAP. Only the display is frozen.
REQ-026 LapHold SHALL be registered and high exactly while State==LAP.
REQ-027 CntClr SHALL be high for exactly the one cycle in which State first reads IDLE after a PAUSE->IDLE transition.
REQ-028 Resuming from PAUSE SHALL continue the prescaler from its held value, so no tick is lost or duplicated.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-030 While nRstIn=0, the following SHALL be cleared asynchronously: State=IDLE, TickEn=0, CntClr=0, LapHold=0, prescaler=0, debounce counters=0, synchronizers=0, stable levels=0.
REQ-031 Reset release SHALL take effect on the first ClkIn rising edge with nRstIn=1. A button already held high at release SHALL produce one press event after DEBOUNCE_CYCLES+2 edges.
REQ-032 Reset asserted mid-operation in any state SHALL return the block to IDLE without issuing a CntClr pulse.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=10)
REQ-033 BtnStartStop held high from IDLE -> State=01 after exactly 6 edges; TickEn pulses every 10 cycles, first pulse 10 cycles after entering RUN.
REQ-034 BtnStartStop toggling every 2 cycles for 20 cycles, then low -> no press event and State remains 00.
REQ-035 RUN, press LC -> State=11, LapHold=1, TickEn still every 10 cycles; press LC again -> State=01, LapHold=0.
REQ-036 RUN, press SS at prescaler=6, wait 50 cycles, press SS -> first TickEn 3 cycles after re-entering RUN; in PAUSE, press LC -> State=00, CntClr high for 1 cycle, prescaler=0.
REQ-037 SS and LC raw inputs rise on the same edge in RUN -> State=10 only; LC is ignored.
REQ-038 nRstIn pulled low in LAP between edges -> outputs read 0 and State=00 immediately, with no CntClr pulse after release.

Source files
------------

// File: rtl/chrono_ctrl.sv
// Stopwatch control: debounced start/stop and lap/clear buttons drive a RUN/PAUSE/LAP FSM
// that gates a tick prescaler. All outputs registered; buttons add DEBOUNCE_CYCLES+2 edges latency.

module chrono_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [DB_W-1:0] CntLast = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_o  = 1'b0;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d    = '0;
      stable_d = sync_q[1];
      // Only the rising acceptance is an event; release is silent.
      press_o  = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

module chrono_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TICK_DIV        = 500000,
  parameter int PRE_W           = 19,
  parameter int DB_W            = 16
) (
  input  logic       ClkIn,
  input  logic       nRstIn,
  input  logic       BtnStartStop,
  input  logic       BtnLapClear,
  output logic       TickEn,
  output logic       CntClr,
  output logic       LapHold,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_e;

  localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICK_DIV - 1);

  logic             ss_press, lc_press;
  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             clr_q, clr_d;
  logic             lap_q, lap_d;
  logic             counting;

  chrono_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_ss (
    .clk_i  (ClkIn),
    .rst_ni (nRstIn),
    .btn_i  (BtnStartStop),
    .press_o(ss_press)
  );

  chrono_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_lc (
    .clk_i  (ClkIn),
    .rst_ni (nRstIn),
    .btn_i  (BtnLapClear),
    .press_o(lc_press)
  );

  assign counting = (state_q == RUN) || (state_q == LAP);

  always_comb begin
    state_d = state_q;
    // Start/stop is checked first everywhere so it wins a simultaneous press.
    case (state_q)
      IDLE:  if (ss_press) state_d = RUN;
      RUN:   if (ss_press) state_d = PAUSE; else if (lc_press) state_d = LAP;
      LAP:   if (ss_press) state_d = PAUSE; else if (lc_press) state_d = RUN;
      PAUSE: if (ss_press) state_d = RUN;   else if (lc_press) state_d = IDLE;
    endcase

    pre_d = pre_q;
    if (state_q == IDLE) begin
      pre_d = '0;
    end else if (counting) begin
      pre_d = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
    end

    tick_d = counting && (pre_q == PreLast);
    clr_d  = (state_q == PAUSE) && (state_d == IDLE);
    lap_d  = (state_d == LAP);
  end

  always_ff @(posedge ClkIn or negedge nRstIn) begin
    if (!nRstIn) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      lap_q   <= lap_d;
    end
  end

  assign TickEn  = tick_q;
  assign CntClr  = clr_q;
  assign LapHold = lap_q;
  assign State   = state_q;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Scoreboard bench for chrono_ctrl (DEBOUNCE_CYCLES=4, TICK_DIV=10): stimulus queues expected
// output snapshots per clock edge count; a negedge monitor pops and compares them.

module tb_chrono_ctrl;

  logic       ClkIn;
  logic       nRstIn;
  logic       BtnStartStop;
  logic       BtnLapClear;
  logic       TickEn;
  logic       CntClr;
  logic       LapHold;
  logic [1:0] State;

  chrono_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (10),
    .PRE_W          (4),
    .DB_W           (3)
  ) dut (
    .ClkIn       (ClkIn),
    .nRstIn      (nRstIn),
    .BtnStartStop(BtnStartStop),
    .BtnLapClear (BtnLapClear),
    .TickEn      (TickEn),
    .CntClr      (CntClr),
    .LapHold     (LapHold),
    .State       (State)
  );

  typedef struct {
    int         cyc;
    logic [4:0] v;   // {State, TickEn, CntClr, LapHold}
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   t;

  initial ClkIn = 1'b0;
  always #5 ClkIn = ~ClkIn;

  always @(posedge ClkIn) cyc <= cyc + 1;

  task automatic push(input int c, input logic [1:0] st, input logic tk, input logic cl,
                      input logic lh);
    exp_t e;
    e.cyc = c;
    e.v   = {st, tk, cl, lh};
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge ClkIn);
      #1;
    end
  endtask

  // Monitor: output snapshot after edge N is compared at the following falling edge.
  always @(negedge ClkIn) begin
    exp_t       e;
    logic [4:0] obs;
    obs = {State, TickEn, CntClr, LapHold};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL missed_check@%0d: monitor at edge %0d, expected entry never compared",
                 e.cyc, cyc);
      end else if (obs !== e.v) begin
        errors++;
        $display("FAIL outputs@%0d: got st=%0d tick=%0b clr=%0b lap=%0b, expected st=%0d tick=%0b clr=%0b lap=%0b",
                 cyc, obs[4:3], obs[2], obs[1], obs[0], e.v[4:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, edge count %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    BtnStartStop = 1'b0;
    BtnLapClear  = 1'b0;
    nRstIn       = 1'b0;
    push(1, 2'd0, 0, 0, 0);
    push(2, 2'd0, 0, 0, 0);
    wait_until(3);
    nRstIn = 1'b1;
    wait_until(6);

    // Start from IDLE: RUN after 6 edges, ticks 10 and 20 edges after entry.
    t = cyc;
    push(t+5,  2'd0, 0, 0, 0);
    push(t+6,  2'd1, 0, 0, 0);
    push(t+15, 2'd1, 0, 0, 0);
    push(t+16, 2'd1, 1, 0, 0);
    push(t+17, 2'd1, 0, 0, 0);
    push(t+26, 2'd1, 1, 0, 0);
    BtnStartStop = 1'b1;
    wait_until(t+8);
    BtnStartStop = 1'b0;
    wait_until(t+27);

    // Lap in RUN, ticks continue, lap again returns to RUN.
    t = cyc;
    push(t+5,  2'd1, 0, 0, 0);
    push(t+6,  2'd3, 0, 0, 1);
    push(t+9,  2'd3, 1, 0, 1);
    push(t+10, 2'd3, 0, 0, 1);
    push(t+19, 2'd3, 1, 0, 1);
    push(t+25, 2'd3, 0, 0, 1);
    push(t+26, 2'd1, 0, 0, 0);
    push(t+29, 2'd1, 1, 0, 0);
    BtnLapClear = 1'b1;
    wait_until(t+8);
    BtnLapClear = 1'b0;
    wait_until(t+20);
    BtnLapClear = 1'b1;
    wait_until(t+28);
    BtnLapClear = 1'b0;
    wait_until(t+40);

    // Pause taken on the edge where the prescaler reads 6; no tick while paused.
    t = cyc;
    push(t+5,  2'd1, 0, 0, 0);
    push(t+6,  2'd2, 0, 0, 0);
    push(t+9,  2'd2, 0, 0, 0);
    push(t+10, 2'd2, 0, 0, 0);
    BtnStartStop = 1'b1;
    wait_until(t+8);
    BtnStartStop = 1'b0;
    wait_until(t+56);

    // Resume: prescaler continues from 7, first tick 3 edges after re-entering RUN.
    t = cyc;
    push(t+5,  2'd2, 0, 0, 0);
    push(t+6,  2'd1, 0, 0, 0);
    push(t+8,  2'd1, 0, 0, 0);
    push(t+9,  2'd1, 1, 0, 0);
    push(t+10, 2'd1, 0, 0, 0);
    push(t+19, 2'd1, 1, 0, 0);
    BtnStartStop = 1'b1;
    wait_until(t+8);
    BtnStartStop = 1'b0;
    wait_until(t+20);

    t = cyc;
    push(t+5, 2'd1, 0, 0, 0);
    push(t+6, 2'd2, 0, 0, 0);
    BtnStartStop = 1'b1;
    wait_until(t+8);
    BtnStartStop = 1'b0;
    wait_until(t+10);

    // Clear from PAUSE: one-cycle CntClr as IDLE appears.
    t = cyc;
    push(t+5, 2'd2, 0, 0, 0);
    push(t+6, 2'd0, 0, 1, 0);
    push(t+7, 2'd0, 0, 0, 0);
    BtnLapClear = 1'b1;
    wait_until(t+8);
    BtnLapClear = 1'b0;
    wait_until(t+10);

    // Restart after clear: prescaler was zeroed, first tick 10 edges after RUN.
    t = cyc;
    push(t+5,  2'd0, 0, 0, 0);
    push(t+6,  2'd1, 0, 0, 0);
    push(t+15, 2'd1, 0, 0, 0);
    push(t+16, 2'd1, 1, 0, 0);
    BtnStartStop = 1'b1;
    wait_until(t+8);
    BtnStartStop = 1'b0;
    wait_until(t+18);

    // Both buttons together in RUN: start/stop wins, lap/clear is dropped.
    t = cyc;
    push(t+5,  2'd1, 0, 0, 0);
    push(t+6,  2'd2, 0, 0, 0);
    push(t+7,  2'd2, 0, 0, 0);
    push(t+8,  2'd2, 0, 0, 0);
    push(t+16, 2'd2, 0, 0, 0);
    BtnStartStop = 1'b1;
    BtnLapClear  = 1'b1;
    wait_until(t+8);
    BtnStartStop = 1'b0;
    BtnLapClear  = 1'b0;
    wait_until(t+16);

    t = cyc;
    push(t+6, 2'd0, 0, 1, 0);
    push(t+7, 2'd0, 0, 0, 0);
    BtnLapClear = 1'b1;
    wait_until(t+8);
    BtnLapClear = 1'b0;
    wait_until(t+16);

    // Bouncing start/stop (2-cycle runs) never qualifies.
    t = cyc;
    push(t+10, 2'd0, 0, 0, 0);
    push(t+20, 2'd0, 0, 0, 0);
    push(t+30, 2'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      BtnStartStop = (i % 2 == 0);
      wait_until(cyc + 2);
    end
    BtnStartStop = 1'b0;
    wait_until(t+32);

    // Enter LAP, reset mid-cycle, then release with start/stop already held.
    t = cyc;
    push(t+6,  2'd1, 0, 0, 0);
    push(t+15, 2'd1, 0, 0, 0);
    push(t+16, 2'd3, 1, 0, 1);
    push(t+17, 2'd3, 0, 0, 1);
    BtnStartStop = 1'b1;
    wait_until(t+8);
    BtnStartStop = 1'b0;
    wait_until(t+10);
    BtnLapClear = 1'b1;
    wait_until(t+18);
    BtnLapClear = 1'b0;
    wait_until(t+20);
    for (int k = 20; k <= 27; k++) push(t+k, 2'd0, 0, 0, 0);
    push(t+28, 2'd1, 0, 0, 0);
    #2;
    nRstIn = 1'b0;
    wait_until(t+21);
    BtnStartStop = 1'b1;
    wait_until(t+22);
    nRstIn = 1'b1;
    wait_until(t+32);
    BtnStartStop = 1'b0;
    wait_until(t+36);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
